// File: rtl/mdr_burst.sv
// Memory data register: moves DATA_W words to/from a MEM_W-wide DRAM port as req/ack beats.
// Define MDR_SIGN_EXT_EN to sign-extend byte-mode reads (default: zero-extend).
module mdr_burst #(
    parameter int DATA_W = 32,
    parameter int MEM_W  = 8,
    localparam int BEATS  = DATA_W / MEM_W,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic              read_en,
    input  logic              write_en,
    input  logic              word_mode,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [BEAT_W-1:0] mem_beat,
    output logic [MEM_W-1:0]  mem_wdata,
    input  logic [MEM_W-1:0]  mem_rdata,
    input  logic              mem_ack
);

    if (DATA_W % MEM_W != 0) begin : g_width_check
        $error("mdr_burst: DATA_W (%0d) must be a multiple of MEM_W (%0d)", DATA_W, MEM_W);
    end

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t state, state_n;

    logic [BEATS-1:0][MEM_W-1:0] shadow, shadow_n;
    logic [BEATS-1:0][MEM_W-1:0] asm_q, asm_n;
    logic                        word_q, word_n;
    logic [DATA_W-1:0]           data_out_n;
    logic                        busy_n, done_n, rd_req_n, wr_req_n;
    logic [BEAT_W-1:0]           beat_n, beat_inc;
    logic [MEM_W-1:0]            wdata_n;
    logic                        is_last;
    logic [DATA_W-1:0]           byte_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            data_out   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            mem_beat   <= '0;
            mem_wdata  <= '0;
            shadow     <= '0;
            asm_q      <= '0;
            word_q     <= 1'b0;
        end else begin
            state      <= state_n;
            data_out   <= data_out_n;
            busy       <= busy_n;
            done       <= done_n;
            mem_rd_req <= rd_req_n;
            mem_wr_req <= wr_req_n;
            mem_beat   <= beat_n;
            mem_wdata  <= wdata_n;
            shadow     <= shadow_n;
            asm_q      <= asm_n;
            word_q     <= word_n;
        end
    end

    always_comb begin
        state_n    = state;
        data_out_n = data_out;
        busy_n     = busy;
        done_n     = 1'b0;
        rd_req_n   = mem_rd_req;
        wr_req_n   = mem_wr_req;
        beat_n     = mem_beat;
        wdata_n    = mem_wdata;
        shadow_n   = shadow;
        asm_n      = asm_q;
        word_n     = word_q;
        beat_inc   = mem_beat + BEAT_W'(1);
        is_last    = (mem_beat == (word_q ? BEAT_W'(BEATS - 1) : '0));

`ifdef MDR_SIGN_EXT_EN
        byte_ext = {DATA_W{mem_rdata[MEM_W-1]}};
`else
        byte_ext = '0;
`endif
        byte_ext[MEM_W-1:0] = mem_rdata;

        case (state)
            IDLE: begin
                if (read_en) begin
                    state_n  = READ;
                    busy_n   = 1'b1;
                    rd_req_n = 1'b1;
                    beat_n   = '0;
                    word_n   = word_mode;
                end else if (write_en) begin
                    state_n  = WRITE;
                    busy_n   = 1'b1;
                    wr_req_n = 1'b1;
                    beat_n   = '0;
                    word_n   = word_mode;
                    shadow_n = data_in;
                    wdata_n  = data_in[MEM_W-1:0];
                end else if (w_en) begin
                    data_out_n = data_in;
                end
            end
            READ: begin
                if (mem_ack) begin
                    asm_n[mem_beat] = mem_rdata;
                    if (is_last) begin
                        // asm_n already holds the final beat, so word data lands in one edge
                        rd_req_n   = 1'b0;
                        busy_n     = 1'b0;
                        done_n     = 1'b1;
                        state_n    = DONE;
                        data_out_n = word_q ? DATA_W'(asm_n) : byte_ext;
                    end else begin
                        beat_n = beat_inc;
                    end
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    if (is_last) begin
                        wr_req_n = 1'b0;
                        busy_n   = 1'b0;
                        done_n   = 1'b1;
                        state_n  = DONE;
                    end else begin
                        beat_n  = beat_inc;
                        wdata_n = shadow[beat_inc];
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                beat_n  = '0;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
